// File: rtl/renkon_pool_pkg.sv
// rtl/renkon_pool_pkg.sv - shared widths and FSM encoding for the renkon pooling stage
package renkon_pool_pkg;

    // Default pixel width, counter width and maximum map width
    localparam int RP_DWIDTH = 16;
    localparam int RP_LWIDTH = 10;
    localparam int RP_MAXW   = 256;

    // Map-level sequencing states
    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_FLUSH = 2'd2
    } state_e;

endpackage

// File: rtl/renkon_pool_buf.sv
// rtl/renkon_pool_buf.sv - line buffer holding horizontal maxima of the even row
module renkon_pool_buf #(
    parameter int DWIDTH = 16,
    parameter int DEPTH  = 128,
    parameter int AW     = 7
) (
    input  logic                     clk,
    input  logic                     we,
    input  logic [AW-1:0]            addr,
    input  logic signed [DWIDTH-1:0] wdata,
    output logic signed [DWIDTH-1:0] rdata
);

    // No reset: every entry is written on the even row before the odd row reads it
    logic [DWIDTH-1:0] mem [DEPTH];

    // Synchronous write of one horizontal pair maximum
    always_ff @(posedge clk) begin
        if (we) begin
            mem[addr] <= wdata;
        end
    end

    // Asynchronous read so the odd-row compare completes in the accepting cycle
    assign rdata = mem[addr];

endmodule

// File: rtl/renkon_pool.sv
// rtl/renkon_pool.sv - 2x2 stride-2 signed max-pooling over a raster pixel stream
module renkon_pool
    import renkon_pool_pkg::*;
#(
    parameter int DWIDTH = RP_DWIDTH,
    parameter int LWIDTH = RP_LWIDTH,
    parameter int MAXW   = RP_MAXW
) (
    input  logic                     clk,
    input  logic                     xrst,
    input  logic                     init,
    input  logic [LWIDTH-1:0]        map_w,
    input  logic [LWIDTH-1:0]        map_h,
    input  logic                     in_valid,
    input  logic signed [DWIDTH-1:0] pixel_in,
    output logic                     out_valid,
    output logic signed [DWIDTH-1:0] pixel_out,
    output logic                     busy,
    output logic                     done
);

    localparam int DEPTH = MAXW / 2;
    localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_e                   state_q, state_d;
    logic [LWIDTH-1:0]        col_q, col_d;
    logic [LWIDTH-1:0]        row_q, row_d;
    logic [LWIDTH-1:0]        w_q, w_d;
    logic [LWIDTH-1:0]        h_q, h_d;
    logic signed [DWIDTH-1:0] hold_q, hold_d;
    logic signed [DWIDTH-1:0] pix_q, pix_d;
    logic                     ov_q, ov_d;
    logic                     busy_q, busy_d;
    logic                     done_q, done_d;

    logic                     accept;
    logic                     last_col;
    logic                     last_px;
    logic                     buf_we;
    logic [AW-1:0]            buf_addr;
    logic signed [DWIDTH-1:0] buf_rdata;
    logic signed [DWIDTH-1:0] hmax;
    logic signed [DWIDTH-1:0] wmax;

    // init wins over a pixel presented in the same cycle; that pixel belongs to the old map
    assign accept   = (state_q == S_RUN) && in_valid && !init;
    assign last_col = (col_q == w_q - LWIDTH'(1));
    assign last_px  = last_col && (row_q == h_q - LWIDTH'(1));

    // Comparator tree: horizontal pair first, then against the stored even-row maximum
    assign hmax = (hold_q > pixel_in) ? hold_q : pixel_in;
    assign wmax = (buf_rdata > hmax) ? buf_rdata : hmax;

    // Even rows write on odd columns, odd rows only read, so no same-address collision
    assign buf_we   = accept && !row_q[0] && col_q[0];
    assign buf_addr = col_q[AW:1];

    renkon_pool_buf #(
        .DWIDTH (DWIDTH),
        .DEPTH  (DEPTH),
        .AW     (AW)
    ) u_buf (
        .clk   (clk),
        .we    (buf_we),
        .addr  (buf_addr),
        .wdata (hmax),
        .rdata (buf_rdata)
    );

    // Next-state logic for the FSM, raster counters, window hold and output register
    always_comb begin
        state_d = state_q;
        col_d   = col_q;
        row_d   = row_q;
        w_d     = w_q;
        h_d     = h_q;
        hold_d  = hold_q;
        pix_d   = pix_q;
        ov_d    = 1'b0;
        done_d  = 1'b0;

        case (state_q)
            S_RUN: begin
                if (accept && last_px) begin
                    state_d = S_FLUSH;
                end
            end
            S_FLUSH: begin
                state_d = S_IDLE;
                done_d  = 1'b1;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (accept) begin
            if (last_col) begin
                col_d = '0;
                row_d = row_q + LWIDTH'(1);
            end else begin
                col_d = col_q + LWIDTH'(1);
            end

            // Odd trailing column/row simply never reaches an odd-odd position
            if (!col_q[0]) begin
                hold_d = pixel_in;
            end else if (row_q[0]) begin
                pix_d = wmax;
                ov_d  = 1'b1;
            end
        end

        // A new map restarts from any state and drops whatever window was half built
        if (init) begin
            state_d = S_RUN;
            col_d   = '0;
            row_d   = '0;
            w_d     = map_w;
            h_d     = map_h;
            done_d  = 1'b0;
        end

        busy_d = (state_d != S_IDLE);
    end

    // State and registered outputs with synchronous active-low reset
    always_ff @(posedge clk) begin
        if (!xrst) begin
            state_q <= S_IDLE;
            col_q   <= '0;
            row_q   <= '0;
            w_q     <= '0;
            h_q     <= '0;
            hold_q  <= '0;
            pix_q   <= '0;
            ov_q    <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            col_q   <= col_d;
            row_q   <= row_d;
            w_q     <= w_d;
            h_q     <= h_d;
            hold_q  <= hold_d;
            pix_q   <= pix_d;
            ov_q    <= ov_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign out_valid = ov_q;
    assign pixel_out = pix_q;
    assign busy      = busy_q;
    assign done      = done_q;

endmodule

// File: tb/tb_renkon_pool.sv
// tb/tb_renkon_pool.sv - self-checking bench for renkon_pool
module tb_renkon_pool;

    localparam int DW = 16;
    localparam int LW = 10;

    logic                 clk = 1'b0;
    logic                 xrst;
    logic                 init;
    logic [LW-1:0]        map_w;
    logic [LW-1:0]        map_h;
    logic                 in_valid;
    logic signed [DW-1:0] pixel_in;
    logic                 out_valid;
    logic signed [DW-1:0] pixel_out;
    logic                 busy;
    logic                 done;

    int nchk = 0;
    int nerr = 0;
    int vals[$];
    int got[$];
    int neg_v[4] = '{-8, -3, -5, -7};

    typedef struct {
        int w;
        int h;
        int gap;
        int kind;
        int abort_n;
        int nexp;
        int e0;
        int e1;
        int e2;
        int e3;
    } vec_t;

    vec_t tbl[6];

    renkon_pool u_dut (
        .clk       (clk),
        .xrst      (xrst),
        .init      (init),
        .map_w     (map_w),
        .map_h     (map_h),
        .in_valid  (in_valid),
        .pixel_in  (pixel_in),
        .out_valid (out_valid),
        .pixel_out (pixel_out),
        .busy      (busy),
        .done      (done)
    );

    always #5 clk = ~clk;

    initial begin
        #3000000;
        $display("FAIL watchdog: time limit reached before summary");
        $fatal(1);
    end

    task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
        nchk++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d expected %0d", nm, act, exp);
        end
    endtask

    function automatic int max4(input int a, input int b, input int c, input int d);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        if (d > m) m = d;
        return m;
    endfunction

    function automatic int pick(input vec_t v, input int j);
        case (j)
            0: return v.e0;
            1: return v.e1;
            2: return v.e2;
            default: return v.e3;
        endcase
    endfunction

    // kind: 0 raster 0.., 1 negative set, 2 raster 1.., 3 random; gap: 0 none, 1 alternate, 2 random
    task automatic run_map(input int w, input int h, input int gap, input int kind, input int abort_n);
        int n, lim, k, cyc, r, c, ev, ep;
        logic v;
        logic signed [DW-1:0] rv;
        n = w * h;
        vals.delete();
        got.delete();
        for (int i = 0; i < n; i++) begin
            case (kind)
                0: vals.push_back(i);
                1: vals.push_back(neg_v[i % 4]);
                2: vals.push_back(i + 1);
                default: begin
                    rv = DW'($urandom);
                    vals.push_back(int'(rv));
                end
            endcase
        end
        lim = (abort_n > 0) ? abort_n : n;

        init     = 1'b1;
        map_w    = LW'(w);
        map_h    = LW'(h);
        in_valid = 1'b0;
        @(posedge clk); #1;
        init = 1'b0;
        chk("busy_after_init", busy, 1);
        chk("ov_after_init", out_valid, 0);

        k = 0;
        cyc = 0;
        while (k < lim && cyc < n * 4 + 20) begin
            case (gap)
                0: v = 1'b1;
                1: v = (cyc % 2 == 0);
                default: v = ($urandom_range(99) >= 30);
            endcase
            ev = 0;
            ep = 0;
            if (v) begin
                r = k / w;
                c = k % w;
                pixel_in = DW'(vals[k]);
                if (r % 2 == 1 && c % 2 == 1) begin
                    ev = 1;
                    ep = max4(vals[(r-1)*w + c-1], vals[(r-1)*w + c], vals[r*w + c-1], vals[r*w + c]);
                end
                k++;
            end else begin
                pixel_in = DW'($urandom);
            end
            in_valid = v;
            @(posedge clk); #1;
            cyc++;
            chk("out_valid", out_valid, ev);
            if (ev != 0 && out_valid) chk("pixel_out", pixel_out, ep);
            if (out_valid) got.push_back(int'(pixel_out));
            chk("busy_run", busy, 1);
            chk("done_run", done, 0);
        end
        in_valid = 1'b0;
        if (k < lim) begin
            nchk++;
            nerr++;
            $display("FAIL feed_budget: fed %0d expected %0d", k, lim);
        end

        if (abort_n == 0) begin
            @(posedge clk); #1;
            chk("done_pulse", done, 1);
            chk("busy_idle", busy, 0);
            chk("ov_idle", out_valid, 0);
            @(posedge clk); #1;
            chk("done_clear", done, 0);
            for (int i = 0; i < 3; i++) begin
                in_valid = 1'b1;
                pixel_in = DW'(100 + i);
                @(posedge clk); #1;
                chk("idle_ignore_ov", out_valid, 0);
                chk("idle_ignore_busy", busy, 0);
            end
            in_valid = 1'b0;
        end
    endtask

    initial begin
        xrst     = 1'b0;
        init     = 1'b0;
        map_w    = '0;
        map_h    = '0;
        in_valid = 1'b0;
        pixel_in = '0;

        tbl[0] = '{4, 4, 0, 0, 0, 4, 5, 7, 13, 15};
        tbl[1] = '{2, 2, 0, 1, 0, 1, -3, 0, 0, 0};
        tbl[2] = '{5, 3, 0, 0, 0, 2, 6, 8, 0, 0};
        tbl[3] = '{4, 4, 1, 0, 0, 4, 5, 7, 13, 15};
        tbl[4] = '{4, 4, 0, 0, 6, 1, 5, 0, 0, 0};
        tbl[5] = '{2, 2, 0, 2, 0, 1, 4, 0, 0, 0};

        repeat (3) @(posedge clk);
        #1;
        chk("rst_out_valid", out_valid, 0);
        chk("rst_pixel_out", pixel_out, 0);
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        xrst = 1'b1;
        @(posedge clk); #1;

        for (int t = 0; t < 6; t++) begin
            run_map(tbl[t].w, tbl[t].h, tbl[t].gap, tbl[t].kind, tbl[t].abort_n);
            chk("tbl_count", got.size(), tbl[t].nexp);
            for (int j = 0; j < tbl[t].nexp; j++) begin
                if (j < got.size()) chk("tbl_value", got[j], pick(tbl[t], j));
            end
        end

        run_map(4, 4, 0, 0, 6);
        chk("pre_reset_ov", out_valid, 1);
        xrst = 1'b0;
        @(posedge clk); #1;
        xrst = 1'b1;
        chk("midrst_ov", out_valid, 0);
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_pix", pixel_out, 0);
        for (int i = 0; i < 8; i++) begin
            in_valid = 1'b1;
            pixel_in = DW'(50 + i);
            @(posedge clk); #1;
            chk("postrst_ov", out_valid, 0);
            chk("postrst_busy", busy, 0);
        end
        in_valid = 1'b0;

        for (int t = 0; t < 6; t++) begin
            int w;
            int h;
            w = (t == 5) ? 256 : int'($urandom_range(24, 2));
            h = (t == 5) ? 3 : int'($urandom_range(9, 2));
            run_map(w, h, 2, 3, 0);
            chk("rand_count", got.size(), (w / 2) * (h / 2));
        end

        $display("Result: errors=%0d of %0d checks", nerr, nchk);
        $finish;
    end

endmodule
